// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: state encoding and a pointer-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_HDR  = 3'b010,
        ARB_PASS = 3'b100
    } arb_state_e;

    // Index width for an n-way pointer, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after
// the pointer, wrapping from NREQ-1 back to 0.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int DW = PW + 1;

    logic [DW-1:0] best_s;
    logic [DW-1:0] dist_s;
    logic [DW-1:0] pos_s;
    logic [DW-1:0] ptr_ext_s;
    logic          take_s;

    // Keep the requester with the smallest cyclic distance from the pointer.
    always_comb begin
        grant_o   = '0;
        best_s    = DW'(NREQ);
        ptr_ext_s = {1'b0, ptr_i};
        dist_s    = '0;
        pos_s     = '0;
        take_s    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            pos_s   = DW'(j);
            dist_s  = (pos_s >= ptr_ext_s) ? (pos_s - ptr_ext_s)
                                           : (pos_s + DW'(NREQ) - ptr_ext_s);
            take_s  = req_i[j] && (dist_s < best_s);
            best_s  = take_s ? dist_s : best_s;
            grant_o = take_s ? (NREQ'(1) << j) : grant_o;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx byte port among NREQ sources.
// Define UART_ARB_TAG_EN to prefix every packet with a header byte holding the source index.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DLEN = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           i_req_valid,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic [NREQ-1:0][DLEN-1:0] i_req_data,
    input  logic [NREQ-1:0]           i_req_last,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    output logic [DLEN-1:0]           o_wdata,
    output logic                      o_busy,
    output logic [NREQ-1:0]           o_grant
);

    localparam int PW = ptr_width(NREQ);

    arb_state_e      state_q;
    logic [NREQ-1:0] grant_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic            busy_q;

    logic [NREQ-1:0] pick_s;
    logic            sel_valid_s;
    logic            sel_last_s;
    logic [DLEN-1:0] sel_data_s;
    logic [PW-1:0]   gidx_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_s)
    );

    // Select the granted requester's signals and its index from the one-hot grant.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        gidx_s      = '0;
        for (int j = 0; j < NREQ; j++) begin
            sel_valid_s = sel_valid_s | (grant_q[j] & i_req_valid[j]);
            sel_last_s  = sel_last_s  | (grant_q[j] & i_req_last[j]);
            sel_data_s  = sel_data_s  | ({DLEN{grant_q[j]}} & i_req_data[j]);
            gidx_s      = gidx_s      | (grant_q[j] ? PW'(j) : '0);
        end
        ptr_d = (gidx_s == PW'(NREQ - 1)) ? '0 : (gidx_s + PW'(1));
    end

    // Line-side outputs: straight pass-through while a packet is granted, idle otherwise.
    always_comb begin
        o_wvalid    = 1'b0;
        o_wdata     = '0;
        o_req_ready = '0;
        case (state_q)
            ARB_PASS: begin
                o_wvalid    = sel_valid_s;
                o_wdata     = sel_valid_s ? sel_data_s : '0;
                o_req_ready = i_wready ? grant_q : '0;
            end
`ifdef UART_ARB_TAG_EN
            ARB_HDR: begin
                o_wvalid    = 1'b1;
                o_wdata     = DLEN'(gidx_s);
                o_req_ready = '0;
            end
`endif
            default: begin
                o_wvalid    = 1'b0;
                o_wdata     = '0;
                o_req_ready = '0;
            end
        endcase
    end

    // Arbitration FSM; the grant is held until the granted packet's last byte is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|i_req_valid) begin
                        grant_q <= pick_s;
                        busy_q  <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        state_q <= ARB_HDR;
`else
                        state_q <= ARB_PASS;
`endif
                    end
                end
`ifdef UART_ARB_TAG_EN
                ARB_HDR: begin
                    if (i_wready) begin
                        state_q <= ARB_PASS;
                    end
                end
`endif
                ARB_PASS: begin
                    if (sel_valid_s && i_wready && sel_last_s) begin
                        state_q <= ARB_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    $error("uart_tx_arbiter: illegal state %b", state_q);
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = busy_q;
    assign o_grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, DLEN=8); byte sources are
// modelled as queues and every byte on the line is compared with a hand-built list.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TAG_EN
    localparam bit TAG_N = 1'b1;
`else
    localparam bit TAG_N = 1'b0;
`endif

    logic            clk;
    logic            rstn;
    logic [3:0]      i_req_valid;
    logic [3:0]      o_req_ready;
    logic [3:0][7:0] i_req_data;
    logic [3:0]      i_req_last;
    logic            o_wvalid;
    logic            i_wready;
    logic [7:0]      o_wdata;
    logic            o_busy;
    logic [3:0]      o_grant;

    logic [8:0] srcq [4][$];
    logic [3:0] en;
    logic [7:0] line_q [$];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_errors = 0;

    uart_tx_arbiter #(.NREQ(4), .DLEN(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_wvalid    (o_wvalid),
        .i_wready    (i_wready),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy),
        .o_grant     (o_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < 4; r++) begin
            if (en[r] && srcq[r].size() > 0) begin
                i_req_valid[r] = 1'b1;
                i_req_data[r]  = srcq[r][0][7:0];
                i_req_last[r]  = srcq[r][0][8];
            end else begin
                i_req_valid[r] = 1'b0;
                i_req_data[r]  = 8'h00;
                i_req_last[r]  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [3:0] acc;
        @(negedge clk);
        acc = rstn ? (i_req_valid & o_req_ready) : 4'b0000;
        if (rstn && o_wvalid && i_wready) line_q.push_back(o_wdata);
        @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) begin
            if (acc[r]) void'(srcq[r].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        srcq[r].push_back({last, d});
    endtask

    task automatic exp_hdr(input int r);
        if (TAG_N) exp_q.push_back(8'(r));
    endtask

    task automatic clear_line();
        line_q.delete();
        exp_q.delete();
    endtask

    // Runs until all expected bytes are on the line and the arbiter is idle again.
    task automatic run_line(input string tag, input bit pulse, input bit chk_g,
                            input logic [3:0] gexp);
        int t;
        t = 0;
        while ((line_q.size() < exp_q.size() || o_busy) && t < 300) begin
            i_wready = pulse ? ~i_wready : 1'b1;
            if (chk_g && o_busy) check({tag, "_grant_hold"}, o_grant, gexp);
            tick();
            t++;
        end
        check({tag, "_line_len"}, line_q.size(), exp_q.size());
        for (int i = 0; i < line_q.size() && i < exp_q.size(); i++)
            check({tag, "_line_byte"}, line_q[i], exp_q[i]);
        check({tag, "_idle_after"}, o_busy, 1'b0);
    endtask

    initial begin
        int n_pre;
        int t;
        logic [7:0] first;

        rstn     = 1'b0;
        i_wready = 1'b0;
        en       = 4'hF;
        drive();
        tick();
        tick();
        check("rst_wvalid", o_wvalid, 1'b0);
        check("rst_ready", o_req_ready, 4'b0000);
        check("rst_wdata", o_wdata, 8'h00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_grant", o_grant, 4'b0000);
        rstn = 1'b1;

        // 1: three-byte packet from req0 with pulsed wready.
        clear_line();
        push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
        exp_hdr(0); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        drive();
        #1;
        check("t1_grant_latency", o_grant, 4'b0000);
        check("t1_no_fwd_idle", o_wvalid, 1'b0);
        tick();
        check("t1_grant", o_grant, 4'b0001);
        check("t1_busy", o_busy, 1'b1);
        run_line("t1", 1'b1, 1'b1, 4'b0001);
        check("t1_grant_clear", o_grant, 4'b0000);

        // Pointer now 1: req1 beats req0.
        clear_line();
        push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
        exp_hdr(1); exp_q.push_back(8'hB1); exp_hdr(0); exp_q.push_back(8'hB0);
        drive();
        run_line("t1b", 1'b0, 1'b0, 4'b0000);

        // 4: reset mid-packet, then arbitration restarts from req0.
        clear_line();
        i_wready = 1'b1;
        push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
        exp_hdr(3); exp_q.push_back(8'h30);
        drive();
        t = 0;
        while (line_q.size() < exp_q.size() && t < 50) begin
            tick();
            t++;
        end
        check("t4_pre_len", line_q.size(), exp_q.size());
        check("t4_pre_grant", o_grant, 4'b1000);
        rstn = 1'b0;
        tick();
        srcq[3].delete();
        drive();
        #1;
        check("t4_wvalid", o_wvalid, 1'b0);
        check("t4_ready", o_req_ready, 4'b0000);
        check("t4_wdata", o_wdata, 8'h00);
        check("t4_busy", o_busy, 1'b0);
        check("t4_grant", o_grant, 4'b0000);
        rstn = 1'b1;
        push(0, 8'h40, 1'b1); push(3, 8'h43, 1'b1);
        exp_hdr(0); exp_q.push_back(8'h40); exp_hdr(3); exp_q.push_back(8'h43);
        drive();
        run_line("t4", 1'b0, 1'b0, 4'b0000);

        // 2: all four request at once, req0/req1 queue a second packet.
        clear_line();
        push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b1); push(0, 8'h58, 1'b1);
        push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b1); push(1, 8'h68, 1'b1);
        push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b1);
        push(3, 8'h80, 1'b0); push(3, 8'h81, 1'b1);
        exp_hdr(0); exp_q.push_back(8'h50); exp_q.push_back(8'h51);
        exp_hdr(1); exp_q.push_back(8'h60); exp_q.push_back(8'h61);
        exp_hdr(2); exp_q.push_back(8'h70); exp_q.push_back(8'h71);
        exp_hdr(3); exp_q.push_back(8'h80); exp_q.push_back(8'h81);
        exp_hdr(0); exp_q.push_back(8'h58);
        exp_hdr(1); exp_q.push_back(8'h68);
        drive();
        run_line("t2", 1'b0, 1'b0, 4'b0000);

        // 3: req2 stalls mid-packet while req1 waits; grant stays locked.
        clear_line();
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        push(1, 8'hD1, 1'b1);
        exp_hdr(2); exp_q.push_back(8'hC0); exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_hdr(1); exp_q.push_back(8'hD1);
        n_pre = TAG_N ? 2 : 1;
        drive();
        t = 0;
        while (line_q.size() < n_pre && t < 50) begin
            tick();
            t++;
        end
        en[2] = 1'b0;
        drive();
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t3_lock_grant", o_grant, 4'b0100);
            check("t3_lock_wvalid", o_wvalid, 1'b0);
            check("t3_lock_wdata", o_wdata, 8'h00);
            tick();
        end
        check("t3_lock_len", line_q.size(), n_pre);
        en[2] = 1'b1;
        drive();
        run_line("t3", 1'b0, 1'b0, 4'b0000);

        // 5: req3 valid with wready held low for 50 cycles.
        clear_line();
        i_wready = 1'b0;
        push(3, 8'h90, 1'b0); push(3, 8'h91, 1'b1);
        exp_hdr(3); exp_q.push_back(8'h90); exp_q.push_back(8'h91);
        drive();
        tick();
        first = TAG_N ? 8'h03 : 8'h90;
        for (int k = 0; k < 50; k++) begin
            check("t5_wvalid", o_wvalid, 1'b1);
            check("t5_wdata", o_wdata, first);
            check("t5_ready", o_req_ready, 4'b0000);
            tick();
        end
        run_line("t5", 1'b0, 1'b1, 4'b1000);

`ifdef UART_ARB_TAG_EN
        // 6: header byte precedes req2's single-byte packet.
        clear_line();
        i_wready = 1'b1;
        push(2, 8'hA5, 1'b1);
        exp_q.push_back(8'h02); exp_q.push_back(8'hA5);
        drive();
        tick();
        check("t6_hdr_wvalid", o_wvalid, 1'b1);
        check("t6_hdr_wdata", o_wdata, 8'h02);
        check("t6_hdr_ready", o_req_ready, 4'b0000);
        tick();
        check("t6_data_wdata", o_wdata, 8'hA5);
        check("t6_data_ready", o_req_ready, 4'b0100);
        run_line("t6", 1'b0, 1'b0, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
